// File: rtl/usb_fifo_reader_pkg.sv
// rtl/usb_fifo_reader_pkg.sv - register map, status/control bit positions and address decode for usb_fifo_reader
package usb_fifo_reader_pkg;

    localparam logic [7:0] ADDR_DATA_DEFAULT   = 8'h20;
    localparam logic [7:0] ADDR_STATUS_DEFAULT = 8'h21;
    localparam logic [7:0] ADDR_CTRL_DEFAULT   = 8'h22;

    localparam int STAT_BIT_EMPTY     = 7;
    localparam int STAT_BIT_FULL      = 6;
    localparam int STAT_BIT_UNDERFLOW = 5;
    localparam int STAT_BIT_OVERFLOW  = 4;

    localparam int CTRL_BIT_FLUSH    = 0;
    localparam int CTRL_BIT_CLRFLAGS = 1;

    localparam logic [31:0] STAT_OFS_FLAGS    = 32'd0;
    localparam logic [31:0] STAT_OFS_COUNT_LO = 32'd1;
    localparam logic [31:0] STAT_OFS_COUNT_HI = 32'd2;
    localparam logic [31:0] STAT_OFS_PUSHED   = 32'd8;
    localparam logic [31:0] STAT_OFS_POPPED   = 32'd12;
    localparam logic [31:0] STAT_OFS_END      = 32'd16;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_DATA,
        REG_STATUS,
        REG_CTRL
    } reg_sel_t;

    function automatic reg_sel_t decode_addr(
        input logic [7:0] addr,
        input logic [7:0] a_data,
        input logic [7:0] a_status,
        input logic [7:0] a_ctrl
    );
        if (addr == a_data)   return REG_DATA;
        if (addr == a_status) return REG_STATUS;
        if (addr == a_ctrl)   return REG_CTRL;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/fifo_sync_fwft.sv
// rtl/fifo_sync_fwft.sv - single-clock first-word-fall-through FIFO with registered full/empty/count/head
module fifo_sync_fwft #(
    parameter int DW    = 32,
    parameter int DEPTH = 512,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count,
    output logic          o_push_ok,
    output logic          o_pop_ok
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic [DW-1:0] r_head;

    logic          w_pop_ok;
    logic          w_push_ok;
    logic [CW-1:0] w_count_next;

    // A pop frees the slot a same-cycle push needs, so full only blocks an unpaired push.
    assign w_pop_ok     = i_rd_en & ~r_empty & ~i_flush;
    assign w_push_ok    = i_wr_en & (~r_full | w_pop_ok) & ~i_flush;
    assign w_count_next = r_count + CW'(w_push_ok) - CW'(w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_head   <= '0;
        end else begin
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_full   <= 1'b0;
                r_empty  <= 1'b1;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count <= w_count_next;
                r_full  <= (w_count_next == FULL_CNT);
                r_empty <= (w_count_next == '0);
            end
            if (!r_empty) begin
                r_head <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_head    = r_head;
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_count   = r_count;
    assign o_push_ok = w_push_ok;
    assign o_pop_ok  = w_pop_ok;

endmodule

// File: rtl/usb_fifo_reader.sv
// rtl/usb_fifo_reader.sv - USB register-bus reader of a capture-word FIFO; USB_FIFO_READER_STATS_EN adds push/pop counters
module usb_fifo_reader
    import usb_fifo_reader_pkg::*;
#(
    parameter int         pDEPTH        = 512,
    parameter int         pBYTECNT_SIZE = 7,
    parameter logic [7:0] pADDR_DATA    = ADDR_DATA_DEFAULT,
    parameter logic [7:0] pADDR_STATUS  = ADDR_STATUS_DEFAULT,
    parameter logic [7:0] pADDR_CTRL    = ADDR_CTRL_DEFAULT
) (
    input  logic                     clk_usb,
    input  logic                     reset,
    input  logic [7:0]               reg_address,
    input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    input  logic [7:0]               reg_datao,
    input  logic                     reg_read,
    input  logic                     reg_write,
    output logic [7:0]               reg_datai,
    input  logic                     word_wr,
    input  logic [31:0]              word_data,
    output logic                     fifo_full,
    output logic                     fifo_empty
);

    localparam int CW = $clog2(pDEPTH) + 1;

    reg_sel_t      w_sel;
    logic [31:0]   w_bcnt;
    logic [31:0]   w_head;
    logic [CW-1:0] w_count;
    logic [15:0]   w_count16;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_ctrl_wr;
    logic          w_flush;
    logic          w_clr_flags;
    logic          w_pop_req;
    logic          w_of_evt;
    logic          w_uf_evt;
    logic [7:0]    w_flags;
    logic [7:0]    w_stat_byte;
    logic [7:0]    w_data_byte;
    logic [7:0]    w_rd_byte;
    logic          w_unused;

    logic          r_read_d;
    logic          r_sel_data_d;
    logic [1:0]    r_bcnt_lo_d;
    logic          r_underflow;
    logic          r_overflow;
    logic [7:0]    r_datai;

    assign w_sel       = decode_addr(reg_address, pADDR_DATA, pADDR_STATUS, pADDR_CTRL);
    assign w_bcnt      = 32'(reg_bytecnt);
    assign w_ctrl_wr   = reg_write & (w_sel == REG_CTRL) & (reg_bytecnt == '0);
    assign w_flush     = w_ctrl_wr & reg_datao[CTRL_BIT_FLUSH];
    assign w_clr_flags = w_ctrl_wr & reg_datao[CTRL_BIT_CLRFLAGS];

    // The pop fires when the byte-3 read of the data register ends, judged on the access just completed.
    assign w_pop_req = r_read_d & ~reg_read & r_sel_data_d & (r_bcnt_lo_d == 2'd3);
    assign w_of_evt  = word_wr & ~w_push_ok & ~w_flush;
    assign w_uf_evt  = w_pop_req & fifo_empty;

    fifo_sync_fwft #(
        .DW    (32),
        .DEPTH (pDEPTH)
    ) u_fifo (
        .clk       (clk_usb),
        .rst       (reset),
        .i_flush   (w_flush),
        .i_wr_en   (word_wr),
        .i_wr_data (word_data),
        .i_rd_en   (w_pop_req),
        .o_head    (w_head),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_count   (w_count),
        .o_push_ok (w_push_ok),
        .o_pop_ok  (w_pop_ok)
    );

    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            r_read_d     <= 1'b0;
            r_sel_data_d <= 1'b0;
            r_bcnt_lo_d  <= 2'd0;
            r_underflow  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_read_d     <= reg_read;
            r_sel_data_d <= (w_sel == REG_DATA);
            r_bcnt_lo_d  <= reg_bytecnt[1:0];
            r_underflow  <= w_uf_evt | (r_underflow & ~w_clr_flags);
            r_overflow   <= w_of_evt | (r_overflow & ~w_clr_flags);
        end
    end

`ifdef USB_FIFO_READER_STATS_EN
    logic [31:0] r_words_pushed;
    logic [31:0] r_words_popped;
    logic [31:0] w_pushed_sh;
    logic [31:0] w_popped_sh;

    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            r_words_pushed <= '0;
            r_words_popped <= '0;
        end else if (w_flush) begin
            r_words_pushed <= '0;
            r_words_popped <= '0;
        end else begin
            if (w_push_ok) r_words_pushed <= r_words_pushed + 32'd1;
            if (w_pop_ok)  r_words_popped <= r_words_popped + 32'd1;
        end
    end

    assign w_pushed_sh = r_words_pushed >> {w_bcnt[1:0], 3'b000};
    assign w_popped_sh = r_words_popped >> {w_bcnt[1:0], 3'b000};
    assign w_unused    = ^reg_datao[7:2];
`else
    assign w_unused    = ^{reg_datao[7:2], w_pop_ok};
`endif

    assign w_count16 = 16'(w_count);

    always_comb begin
        w_flags                     = 8'h00;
        w_flags[STAT_BIT_EMPTY]     = fifo_empty;
        w_flags[STAT_BIT_FULL]      = fifo_full;
        w_flags[STAT_BIT_UNDERFLOW] = r_underflow;
        w_flags[STAT_BIT_OVERFLOW]  = r_overflow;

        w_stat_byte = 8'h00;
        if (w_bcnt == STAT_OFS_FLAGS) begin
            w_stat_byte = w_flags;
        end else if (w_bcnt == STAT_OFS_COUNT_LO) begin
            w_stat_byte = w_count16[7:0];
        end else if (w_bcnt == STAT_OFS_COUNT_HI) begin
            w_stat_byte = w_count16[15:8];
`ifdef USB_FIFO_READER_STATS_EN
        end else if (w_bcnt >= STAT_OFS_PUSHED && w_bcnt < STAT_OFS_POPPED) begin
            w_stat_byte = w_pushed_sh[7:0];
        end else if (w_bcnt >= STAT_OFS_POPPED && w_bcnt < STAT_OFS_END) begin
            w_stat_byte = w_popped_sh[7:0];
`endif
        end
    end

    always_comb begin
        w_data_byte = 8'h00;
        if (!fifo_empty) begin
            case (reg_bytecnt[1:0])
                2'd0:    w_data_byte = w_head[7:0];
                2'd1:    w_data_byte = w_head[15:8];
                2'd2:    w_data_byte = w_head[23:16];
                default: w_data_byte = w_head[31:24];
            endcase
        end
    end

    always_comb begin
        w_rd_byte = 8'h00;
        case (w_sel)
            REG_DATA:   w_rd_byte = w_data_byte;
            REG_STATUS: w_rd_byte = w_stat_byte;
            default:    w_rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            r_datai <= 8'h00;
        end else begin
            r_datai <= reg_read ? w_rd_byte : 8'h00;
        end
    end

    assign reg_datai = r_datai;

endmodule

// File: tb/tb_usb_fifo_reader.sv
// tb/tb_usb_fifo_reader.sv - self-checking bench for usb_fifo_reader (vector table plus scoreboard)
module tb_usb_fifo_reader;

    localparam int         DEPTH       = 16;
    localparam int         BCW         = 7;
    localparam logic [7:0] ADDR_DATA   = 8'h20;
    localparam logic [7:0] ADDR_STATUS = 8'h21;
    localparam logic [7:0] ADDR_CTRL   = 8'h22;

    logic           clk_usb = 1'b0;
    logic           reset;
    logic [7:0]     reg_address;
    logic [BCW-1:0] reg_bytecnt;
    logic [7:0]     reg_datao;
    logic           reg_read;
    logic           reg_write;
    logic [7:0]     reg_datai;
    logic           word_wr;
    logic [31:0]    word_data;
    logic           fifo_full;
    logic           fifo_empty;

    always #5 clk_usb = ~clk_usb;

    usb_fifo_reader #(
        .pDEPTH        (DEPTH),
        .pBYTECNT_SIZE (BCW)
    ) dut (
        .clk_usb     (clk_usb),
        .reset       (reset),
        .reg_address (reg_address),
        .reg_bytecnt (reg_bytecnt),
        .reg_datao   (reg_datao),
        .reg_read    (reg_read),
        .reg_write   (reg_write),
        .reg_datai   (reg_datai),
        .word_wr     (word_wr),
        .word_data   (word_data),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty)
    );

    typedef struct {
        logic [7:0] addr;
        int         bcnt;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] m_q[$];
    bit          m_uf;
    bit          m_of;
    logic [7:0]  sb_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic add_vec(input logic [7:0] addr, input int bcnt, input logic [7:0] exp, input string name);
        vec_t v;
        v.addr = addr;
        v.bcnt = bcnt;
        v.exp  = exp;
        v.name = name;
        vecs.push_back(v);
    endtask

    function automatic logic [7:0] m_data(input int b);
        logic [31:0] w;
        if (m_q.size() == 0) return 8'h00;
        w = m_q[0];
        return w[8*(b%4) +: 8];
    endfunction

    function automatic logic [7:0] m_status(input int b);
        logic [15:0] c;
        c = 16'(m_q.size());
        case (b)
            0:       return {m_q.size() == 0, m_q.size() == DEPTH, m_uf, m_of, 4'b0000};
            1:       return c[7:0];
            2:       return c[15:8];
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_push(input logic [31:0] w);
        if (m_q.size() < DEPTH) m_q.push_back(w);
        else m_of = 1'b1;
    endtask

    task automatic model_pop();
        if (m_q.size() == 0) m_uf = 1'b1;
        else void'(m_q.pop_front());
    endtask

    task automatic model_reset();
        m_q.delete();
        m_uf = 1'b0;
        m_of = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        @(negedge clk_usb);
        word_wr   = 1'b1;
        word_data = w;
        @(negedge clk_usb);
        word_wr = 1'b0;
        model_push(w);
    endtask

    // One byte read; optionally a producer push lands in the same cycle as the pop edge.
    task automatic read_byte(input logic [7:0] addr, input int b, input logic [7:0] exp,
                             input string name, input bit push_at_end, input logic [31:0] pw);
        logic [7:0] got;
        @(negedge clk_usb);
        reg_address = addr;
        reg_bytecnt = BCW'(b);
        reg_read    = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk_usb);
        got = reg_datai;
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty, got %h", name, got);
        end else begin
            check(name, {24'h0, got}, {24'h0, sb_q.pop_front()});
        end
        reg_read = 1'b0;
        if (push_at_end) begin
            word_wr   = 1'b1;
            word_data = pw;
        end
        if (addr == ADDR_DATA && (b % 4) == 3) model_pop();
        if (push_at_end) model_push(pw);
        @(negedge clk_usb);
        word_wr = 1'b0;
        repeat (3) @(negedge clk_usb);
    endtask

    task automatic read_data(input int b, input string name);
        read_byte(ADDR_DATA, b, m_data(b), name, 1'b0, 32'h0);
    endtask

    task automatic read_status(input int b, input string name);
        read_byte(ADDR_STATUS, b, m_status(b), name, 1'b0, 32'h0);
    endtask

    task automatic ctrl_write(input logic [7:0] d, input bit push, input logic [31:0] w);
        @(negedge clk_usb);
        reg_address = ADDR_CTRL;
        reg_bytecnt = '0;
        reg_datao   = d;
        reg_write   = 1'b1;
        if (push) begin
            word_wr   = 1'b1;
            word_data = w;
        end
        @(negedge clk_usb);
        reg_write = 1'b0;
        word_wr   = 1'b0;
        if (d[0]) m_q.delete();
        if (d[1]) begin
            m_uf = 1'b0;
            m_of = 1'b0;
        end
        if (push && !d[0]) model_push(w);
    endtask

    initial begin
        reset       = 1'b1;
        reg_address = 8'h00;
        reg_bytecnt = '0;
        reg_datao   = 8'h00;
        reg_read    = 1'b0;
        reg_write   = 1'b0;
        word_wr     = 1'b0;
        word_data   = 32'h0;
        model_reset();
        repeat (2) @(negedge clk_usb);
        check("reset_datai", {24'h0, reg_datai}, 32'h0);
        check("reset_empty", {31'h0, fifo_empty}, 32'h1);
        check("reset_full", {31'h0, fifo_full}, 32'h0);
        reset = 1'b0;
        read_status(0, "reset_status0");
        read_status(1, "reset_count");

        push_word(32'hA1B2C3D4);
        add_vec(ADDR_STATUS, 1, 8'h01, "one_word_count");
        add_vec(ADDR_STATUS, 0, 8'h00, "one_word_status0");
        add_vec(ADDR_DATA, 0, 8'hD4, "data_b0");
        add_vec(ADDR_DATA, 1, 8'hC3, "data_b1");
        add_vec(ADDR_DATA, 2, 8'hB2, "data_b2");
        add_vec(ADDR_DATA, 3, 8'hA1, "data_b3");
        add_vec(ADDR_STATUS, 0, 8'h80, "after_pop_status0");
        add_vec(ADDR_STATUS, 1, 8'h00, "after_pop_count_lo");
        add_vec(ADDR_STATUS, 2, 8'h00, "after_pop_count_hi");
        add_vec(ADDR_STATUS, 7, 8'h00, "status_b7");
`ifndef USB_FIFO_READER_STATS_EN
        add_vec(ADDR_STATUS, 8, 8'h00, "status_b8_nostats");
`endif
        add_vec(ADDR_STATUS, 100, 8'h00, "status_b100");
        add_vec(8'h30, 0, 8'h00, "unmapped_addr");
        add_vec(ADDR_CTRL, 0, 8'h00, "ctrl_read");
        for (int i = 0; i < vecs.size(); i++) begin
            read_byte(vecs[i].addr, vecs[i].bcnt, vecs[i].exp, vecs[i].name, 1'b0, 32'h0);
        end
        check("table_end_empty", {31'h0, fifo_empty}, 32'h1);

        for (int i = 0; i < DEPTH + 1; i++) begin
            push_word($urandom);
            if (i == DEPTH - 2) check("full_before_depth", {31'h0, fifo_full}, 32'h0);
            if (i == DEPTH - 1) check("full_at_depth", {31'h0, fifo_full}, 32'h1);
        end
        check("model_overflow", {31'h0, m_of}, 32'h1);
        read_status(0, "overflow_status0");
        read_status(1, "overflow_count_lo");
        read_status(2, "overflow_count_hi");

        ctrl_write(8'h02, 1'b0, 32'h0);
        read_status(0, "full_cleared_status0");
        read_data(0, "full_head_b0");
        read_data(1, "full_head_b1");
        read_data(2, "full_head_b2");
        read_byte(ADDR_DATA, 3, m_data(3), "full_head_b3_pushpop", 1'b1, 32'hCAFE0001);
        read_status(0, "pushpop_status0");
        read_status(1, "pushpop_count");
        check("pushpop_full", {31'h0, fifo_full}, 32'h1);
        for (int w = 0; w < DEPTH; w++) begin
            for (int b = 0; b < 4; b++) read_data(b, "drain");
        end
        check("drain_empty", {31'h0, fifo_empty}, 32'h1);

        for (int b = 0; b < 4; b++) read_data(b, "empty_read");
        read_status(0, "underflow_status0");
        ctrl_write(8'h02, 1'b0, 32'h0);
        read_status(0, "clrflags_status0");
        read_byte(ADDR_DATA, 3, 8'h00, "empty_pushpop_b3", 1'b1, 32'h5A6B7C8D);
        read_status(0, "empty_pushpop_status0");
        read_status(1, "empty_pushpop_count");
        read_data(0, "empty_pushpop_head");
        ctrl_write(8'h03, 1'b0, 32'h0);
        read_status(0, "flush_clr_status0");

        push_word(32'h00000001);
        push_word(32'h00000002);
        push_word(32'h00000003);
        read_status(1, "three_count");
        ctrl_write(8'h01, 1'b1, 32'h00000004);
        read_status(0, "flush_push_status0");
        read_status(1, "flush_push_count");
        check("flush_push_empty", {31'h0, fifo_empty}, 32'h1);

        push_word(32'h11223344);
        @(negedge clk_usb);
        @(negedge clk_usb);
        reg_address = ADDR_DATA;
        reg_bytecnt = BCW'(2);
        reg_read    = 1'b1;
        @(negedge clk_usb);
        check("pre_reset_b2", {24'h0, reg_datai}, {24'h0, m_data(2)});
        #2 reset = 1'b1;
        #1 check("datai_async_reset", {24'h0, reg_datai}, 32'h0);
        reg_read = 1'b0;
        model_reset();
        @(negedge clk_usb);
        reset = 1'b0;
        repeat (2) @(negedge clk_usb);
        read_status(0, "post_reset_status0");
        read_status(1, "post_reset_count");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
